aes_round_ctrl: RTL and testbench

Sequencing controller for the iterative AES-128 encryption datapath. It runs the four round stages (sub_bytes, shift_rows, mix_columns, add_round_key) through the initial key addition, NR-1 full rounds and the final round without mix_columns. It drives each stage with a one-cycle enable and waits for that stage's done flag. It supplies the round index to the key schedule and reports completion, or a stage timeout, to the top level.

---
 rtl/aes_pkg.sv | 9 +
 rtl/aes_stage_timer.sv | 18 +
 rtl/aes_round_ctrl.sv | 82 ++++++++
 tb/tb_aes_round_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared state type and constants for the AES-128 round controller
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int AES_ROUND_W = 4;
  typedef enum logic [3:0] {IDLE, LOAD, ARK0, SB, SR, MC, ARK, DONE, ERR} aes_round_ctrl_state_t;
  function automatic logic is_stage(aes_round_ctrl_state_t s);
    return s inside {ARK0, SB, SR, MC, ARK};
  endfunction
endpackage

// File: rtl/aes_stage_timer.sv
// aes_stage_timer: saturating per-stage wait counter, the entry cycle counts as the first wait cycle
module aes_stage_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic tick,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  logic [CW-1:0] cnt;
  always_ff @(posedge CLK) begin
    cnt <= RST ? '0 : clear ? CW'(1) : (tick && cnt != TMAX) ? cnt + 1'b1 : cnt;
  end
  assign expired = cnt == TMAX;
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences the AES-128 round stages, tracks the round index and flags stage timeouts
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   sb_done,
  input  logic                   sr_done,
  input  logic                   mc_done,
  input  logic                   ark_done,
  output logic                   load_in,
  output logic                   sb_en,
  output logic                   sr_en,
  output logic                   mc_en,
  output logic                   ark_en,
  output logic [AES_ROUND_W-1:0] round,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam logic [AES_ROUND_W-1:0] NR_R = AES_ROUND_W'(NR);
  aes_round_ctrl_state_t state, nxt;
  logic stage_done, first, adv, last, accept, in_stage, enter, expired;
  aes_stage_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK(CLK),
    .RST(RST),
    .clear(enter),
    .tick(in_stage),
    .expired(expired)
  );
  always_comb begin
    first = sb_en | sr_en | mc_en | ark_en;
    stage_done = (state inside {ARK0, ARK}) ? ark_done : (state == SB) ? sb_done :
                 (state == SR) ? sr_done : (state == MC) ? mc_done : 1'b0;
    // the enable cycle is where the stage registers its result, so its done flag is not trusted yet
    adv = stage_done && !first;
    last = round == NR_R;
    accept = state == IDLE && start;
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = ARK0;
      ARK0:    nxt = adv ? SB : expired ? ERR : ARK0;
      SB:      nxt = adv ? SR : expired ? ERR : SB;
      SR:      nxt = adv ? (last ? ARK : MC) : expired ? ERR : SR;
      MC:      nxt = adv ? ARK : expired ? ERR : MC;
      ARK:     nxt = adv ? (last ? DONE : SB) : expired ? ERR : ARK;
      default: nxt = IDLE;
    endcase
    in_stage = is_stage(state);
    enter = is_stage(nxt) && nxt != state;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      load_in <= 1'b0;
      sb_en   <= 1'b0;
      sr_en   <= 1'b0;
      mc_en   <= 1'b0;
      ark_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      round   <= '0;
    end else begin
      state   <= nxt;
      load_in <= nxt == LOAD;
      sb_en   <= enter && nxt == SB;
      sr_en   <= enter && nxt == SR;
      mc_en   <= enter && nxt == MC;
      ark_en  <= enter && (nxt == ARK0 || nxt == ARK);
      busy    <= nxt inside {LOAD, ARK0, SB, SR, MC, ARK};
      done    <= nxt == DONE;
      err     <= nxt == ERR || (err && !accept);
      round   <= accept ? '0 : (enter && nxt == SB) ? round + 1'b1 : round;
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench with stage responders and a stage-list timing model
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam int TMO = 16;
  logic clk = 1'b0;
  logic RST = 1'b1;
  logic start = 1'b0;
  logic sb_done = 1'b0, sr_done = 1'b0, mc_done = 1'b0, ark_done = 1'b0;
  logic load_in, sb_en, sr_en, mc_en, ark_en, busy, done, err;
  logic [3:0] round;
  logic start1 = 1'b0;
  logic sb_done1 = 1'b0, sr_done1 = 1'b0, mc_done1 = 1'b0, ark_done1 = 1'b0;
  logic load_in1, sb_en1, sr_en1, mc_en1, ark_en1, busy1, done1, err1;
  logic [3:0] round1;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_round_ctrl #(.NR(NR), .TIMEOUT(TMO)) dut (
    .CLK(clk), .RST(RST), .start(start),
    .sb_done(sb_done), .sr_done(sr_done), .mc_done(mc_done), .ark_done(ark_done),
    .load_in(load_in), .sb_en(sb_en), .sr_en(sr_en), .mc_en(mc_en), .ark_en(ark_en),
    .round(round), .busy(busy), .done(done), .err(err)
  );
  aes_round_ctrl #(.NR(1), .TIMEOUT(TMO)) dut1 (
    .CLK(clk), .RST(RST), .start(start1),
    .sb_done(sb_done1), .sr_done(sr_done1), .mc_done(mc_done1), .ark_done(ark_done1),
    .load_in(load_in1), .sb_en(sb_en1), .sr_en(sr_en1), .mc_en(mc_en1), .ark_en(ark_en1),
    .round(round1), .busy(busy1), .done(done1), .err(err1)
  );

  typedef struct {
    int load_cyc;
    int end_cyc;
    bit is_err;
    int n_sb, n_sr, n_mc, n_ark;
  } exp_t;
  exp_t q[$];
  exp_t q1[$];

  // per-run plan: one stage occurrence may be slowed (delay 0 = never answers)
  int st_stage = -1, st_round = 0, st_delay = 1;
  bit noise = 0, spur = 0, busy_start = 0, done_start = 0;

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  function automatic int delay_of(int s, int r);
    return (s == st_stage && r == st_round) ? st_delay : 1;
  endfunction

  // walk the stage list: ARK0, then per round SB SR [MC] ARK; each stage costs its done delay + 1
  function automatic exp_t predict(int k, int nr, bit use_plan);
    exp_t e;
    int t, d;
    e.load_cyc = k + 1;
    e.end_cyc = 0;
    e.is_err = 0;
    e.n_sb = 0; e.n_sr = 0; e.n_mc = 0; e.n_ark = 0;
    t = k + 2;
    for (int r = 0; r <= nr; r++)
      for (int s = 0; s < 4; s++) begin
        if ((r == 0 && s != 3) || (r == nr && s == 2)) continue;
        if (s == 0) e.n_sb++;
        else if (s == 1) e.n_sr++;
        else if (s == 2) e.n_mc++;
        else e.n_ark++;
        d = use_plan ? delay_of(s, r) : 1;
        if (d == 0 || d >= TMO) begin
          e.is_err = 1;
          e.end_cyc = t + TMO;
          return e;
        end
        t += d + 1;
      end
    e.end_cyc = t;
    return e;
  endfunction

  // stage responders for the NR=10 instance
  int cnt[4];
  bit armed[4];
  int active = -1;
  int rr = 0;
  always @(negedge clk) begin
    logic [3:0] en, dn;
    en = {ark_en, mc_en, sr_en, sb_en};
    dn = '0;
    if (load_in || RST) begin
      rr = 0;
      active = -1;
      for (int s = 0; s < 4; s++) armed[s] = 0;
    end
    if (sb_en) rr++;
    for (int s = 0; s < 4; s++)
      if (armed[s]) begin
        cnt[s]--;
        if (cnt[s] == 0) begin
          dn[s] = 1'b1;
          armed[s] = 0;
        end
      end
    for (int s = 0; s < 4; s++)
      if (en[s]) begin
        active = s;
        cnt[s] = delay_of(s, rr);
        armed[s] = cnt[s] > 0;
        if (spur) dn[s] = 1'b1;
      end
    if (noise)
      for (int s = 0; s < 4; s++)
        if (s != active && $urandom_range(0, 3) == 0) dn[s] = 1'b1;
    {ark_done, mc_done, sr_done, sb_done} = dn;
  end

  // monitor for the NR=10 instance
  int m_sb = 0, m_sr = 0, m_mc = 0, m_ark = 0;
  logic err_q = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!RST) begin
      if (load_in) begin
        chk("load_pending", q.size(), 1);
        if (q.size() > 0) chk("load_cyc", cyc, q[0].load_cyc);
        chk("load_round", int'(round), 0);
        chk("load_err_clear", int'(err), 0);
        m_sb = 0; m_sr = 0; m_mc = 0; m_ark = 0;
      end
      m_sb += int'(sb_en);
      m_sr += int'(sr_en);
      m_mc += int'(mc_en);
      m_ark += int'(ark_en);
      if (mc_en) chk("mc_en_round_lt_nr", int'(int'(round) < NR), 1);
      if (done || (err && !err_q)) begin
        chk("end_pending", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("end_cyc", cyc, e.end_cyc);
          chk("end_err", int'(err), int'(e.is_err));
          chk("end_done", int'(done), int'(!e.is_err));
          chk("n_sb", m_sb, e.n_sb);
          chk("n_sr", m_sr, e.n_sr);
          chk("n_mc", m_mc, e.n_mc);
          chk("n_ark", m_ark, e.n_ark);
          chk("busy_at_end", int'(busy), 0);
          if (e.is_err) chk("en_at_err", int'({sb_en, sr_en, mc_en, ark_en}), 0);
          else chk("round_at_done", int'(round), NR);
        end
      end
    end
    err_q = err;
  end

  // NR=1 instance: every stage answers one cycle after its enable
  logic [3:0] en1_q = '0;
  int m1_sb = 0, m1_sr = 0, m1_mc = 0, m1_ark = 0, n1_done = 0;
  always @(negedge clk) begin
    {ark_done1, mc_done1, sr_done1, sb_done1} = en1_q;
    en1_q = {ark_en1, mc_en1, sr_en1, sb_en1};
  end
  always @(negedge clk) begin
    exp_t e;
    if (!RST) begin
      if (load_in1) begin
        chk("nr1_load_pending", q1.size(), 1);
        if (q1.size() > 0) chk("nr1_load_cyc", cyc, q1[0].load_cyc);
        m1_sb = 0; m1_sr = 0; m1_mc = 0; m1_ark = 0;
      end
      m1_sb += int'(sb_en1);
      m1_sr += int'(sr_en1);
      m1_mc += int'(mc_en1);
      m1_ark += int'(ark_en1);
      if (done1 || err1) begin
        chk("nr1_end_pending", q1.size(), 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("nr1_end_cyc", cyc, e.end_cyc);
          chk("nr1_err", int'(err1), 0);
          chk("nr1_n_sb", m1_sb, e.n_sb);
          chk("nr1_n_sr", m1_sr, e.n_sr);
          chk("nr1_n_mc", m1_mc, e.n_mc);
          chk("nr1_n_ark", m1_ark, e.n_ark);
          n1_done++;
        end
      end
    end
  end
  initial begin
    exp_t e;
    @(negedge clk);
    while (cyc < 5) @(negedge clk);
    e = predict(cyc, 1, 0);
    q1.push_back(e);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
  end

  task automatic check_zero(string tag);
    chk({tag, "_load_in"}, int'(load_in), 0);
    chk({tag, "_enables"}, int'({sb_en, sr_en, mc_en, ark_en}), 0);
    chk({tag, "_round"}, int'(round), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic set_plan(int stg, int rnd, int dly, bit nz, bit sp, bit bs, bit ds);
    st_stage = stg; st_round = rnd; st_delay = dly;
    noise = nz; spur = sp; busy_start = bs; done_start = ds;
  endtask

  task automatic run_one();
    int k, lim;
    exp_t e;
    k = cyc;
    e = predict(k, NR, 1);
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim = 0;
    while (!(done || (err && cyc > k + 1))) begin
      if (lim >= 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL run_bound: no done or err within %0d cycles of start at %0d", lim, k);
        q.delete();
        break;
      end
      start = busy_start && busy && $urandom_range(0, 2) == 0;
      @(negedge clk);
      start = 1'b0;
      lim++;
    end
    if (done && done_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("idle_after_run", int'(busy), 0);
  endtask

  initial begin
    int lim;
    exp_t e;
    repeat (3) @(negedge clk);
    check_zero("reset");
    RST = 1'b0;
    while (cyc < 5) @(negedge clk);
    set_plan(-1, 0, 1, 0, 0, 0, 0); run_one();
    set_plan(0, 3, 5, 0, 0, 0, 0);  run_one();
    set_plan(2, 2, 0, 0, 0, 0, 0);  run_one();
    set_plan(-1, 0, 1, 0, 0, 0, 0); run_one();
    set_plan(-1, 0, 1, 0, 1, 0, 0); run_one();
    set_plan(-1, 0, 1, 1, 0, 0, 0); run_one();
    set_plan(-1, 0, 1, 0, 0, 1, 0); run_one();
    set_plan(-1, 0, 1, 0, 0, 0, 1); run_one();
    set_plan(1, 4, TMO - 1, 0, 0, 0, 0); run_one();
    set_plan(3, 0, TMO, 0, 0, 0, 0); run_one();
    // abort during round 5 SR
    set_plan(-1, 0, 1, 0, 0, 0, 0);
    e = predict(cyc, NR, 1);
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim = 0;
    while (!(int'(round) == 5 && sr_en) && lim < 200) begin
      @(negedge clk);
      lim++;
    end
    chk("reach_r5_sr", int'(int'(round) == 5 && sr_en), 1);
    RST = 1'b1;
    q.delete();
    @(negedge clk);
    RST = 1'b0;
    check_zero("midreset");
    @(negedge clk);
    run_one();
    repeat (16) begin
      int stg, rnd;
      stg = int'($urandom_range(0, 4)) - 1;
      rnd = stg == 3 ? int'($urandom_range(0, NR)) : stg == 2 ? int'($urandom_range(1, NR - 1)) : int'($urandom_range(1, NR));
      set_plan(stg, rnd,
               $urandom_range(0, 3) == 0 ? int'($urandom_range(0, TMO + 2)) : int'($urandom_range(1, 4)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run_one();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("nr1_done_count", n1_done, 1);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1, "watchdog");
  end
endmodule
